// File: rtl/sobel_window_ctrl_if.sv
// Bus bundle for sobel_window_ctrl.
// Groups three signal sets:
//   - the source pixel handshake (data_valid / in_ready)
//   - the line-buffer write port (lb_wr_en / lb_wr_bank / lb_wr_addr)
//   - the window handshake to the convolution engine (win_*)
// It also carries frame control and status (start, busy, done, win_count).
// The master modport is the controller side; the slave modport is the environment side.
interface sobel_window_ctrl_if #(
    parameter int unsigned CW = 19
);
    logic          start;
    logic          data_valid;
    logic          in_ready;
    logic          lb_wr_en;
    logic [1:0]    lb_wr_bank;
    logic [9:0]    lb_wr_addr;
    logic          win_valid;
    logic          win_ready;
    logic [1:0]    win_bank_new;
    logic [9:0]    win_col;
    logic [9:0]    win_row;
    logic [CW-1:0] win_count;
    logic          busy;
    logic          done;

    modport master (
        input  start, data_valid, win_ready,
        output in_ready, lb_wr_en, lb_wr_bank, lb_wr_addr,
        output win_valid, win_bank_new, win_col, win_row, win_count, busy, done
    );

    modport slave (
        output start, data_valid, win_ready,
        input  in_ready, lb_wr_en, lb_wr_bank, lb_wr_addr,
        input  win_valid, win_bank_new, win_col, win_row, win_count, busy, done
    );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Streaming scheduler for the Sobel pipeline. It takes raster-order pixels and writes each one
// into a three-bank rotating line buffer. Once a full 3x3 interior window exists, it presents
// that window to the convolution engine. It handles one frame per start.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous reset, active high (1 = reset)
//   bus   - sobel_window_ctrl_if.master. Carries the pixel handshake, the line-buffer write
//           port, the window handshake, and the frame status.
module sobel_window_ctrl #(
    parameter int unsigned N  = 450,
    parameter int unsigned M  = 600,
    parameter int unsigned CW = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sobel_window_ctrl_if.master  bus
);

    localparam logic [9:0] ColLast = 10'(M - 1);
    localparam logic [9:0] RowLast = 10'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e        state_q, state_d;
    logic [9:0]    row_q, row_d;
    logic [9:0]    col_q, col_d;
    logic [1:0]    bank_q, bank_d;
    logic          win_valid_q, win_valid_d;
    logic [1:0]    win_bank_q, win_bank_d;
    logic [9:0]    win_row_q, win_row_d;
    logic [9:0]    win_col_q, win_col_d;
    logic [CW-1:0] win_count_q, win_count_d;

    logic in_ready;
    logic accept;
    logic win_hs;
    logic win_load;

    // Stall the source whenever an unaccepted window is pending, so the next
    // pixel can never overwrite the bank the pending window still points at.
    assign in_ready = (state_q == StRun) && (!win_valid_q || bus.win_ready);
    assign accept   = bus.data_valid && in_ready;
    assign win_hs   = win_valid_q && bus.win_ready;
    assign win_load = accept && (row_q >= 10'd2) && (col_q >= 10'd2);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        bank_d      = bank_q;
        win_valid_d = win_valid_q;
        win_bank_d  = win_bank_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_count_d = win_count_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d     = StRun;
                    row_d       = '0;
                    col_d       = '0;
                    bank_d      = '0;
                    win_count_d = '0;
                end
            end
            StRun: begin
                if (accept && (row_q == RowLast) && (col_q == ColLast)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (win_hs) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            if (col_q == ColLast) begin
                col_d  = '0;
                row_d  = row_q + 10'd1;
                bank_d = (bank_q == 2'd2) ? 2'd0 : bank_q + 2'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end

        if (win_hs) begin
            win_count_d = win_count_q + CW'(1);
            win_valid_d = 1'b0;
        end

        // A window loading on the same edge as a handshake replaces the old one.
        if (win_load) begin
            win_valid_d = 1'b1;
            win_bank_d  = bank_q;
            win_row_d   = row_q - 10'd1;
            win_col_d   = col_q - 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            bank_q      <= '0;
            win_valid_q <= 1'b0;
            win_bank_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_count_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            bank_q      <= bank_d;
            win_valid_q <= win_valid_d;
            win_bank_q  <= win_bank_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_count_q <= win_count_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.lb_wr_en     = accept;
    assign bus.lb_wr_bank   = bank_q;
    assign bus.lb_wr_addr   = col_q;
    assign bus.win_valid    = win_valid_q;
    assign bus.win_bank_new = win_bank_q;
    assign bus.win_row      = win_row_q;
    assign bus.win_col      = win_col_q;
    assign bus.win_count    = win_count_q;
    assign bus.busy         = (state_q == StRun) || (state_q == StFlush);
    assign bus.done         = (state_q == StDone);

endmodule
